// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl
//   Burst controller sitting in front of a 2^AW x DW combinational-write
//   scratch memory. Accepts read/write burst commands over valid/ready,
//   streams write beats into the memory and read beats out of it. All memory
//   side outputs (mem_we, mem_addr, mem_din) are flops that change on the same
//   clock edge, so the memory never sees skew while mem_we is high.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_write, cmd_addr, cmd_len    burst direction, start address, beats-1
//   wdata_valid/wdata_ready, wdata  write beat stream
//   rdata_valid/rdata_ready, rdata  read beat stream
//   busy                            controller not idle
//   done                            one-cycle pulse in first IDLE cycle after a burst
//   mem_we, mem_addr, mem_din       registered memory drive
//   mem_dout                        memory read data (combinational from mem_addr)
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | ready for a command; may still be finishing the last write pulse
// WRITE    | accepting write beats, one memory write per accepted beat
// RD_FETCH | address presented to memory, read data captured at next edge
// RD_HOLD  | read beat held on rdata until the consumer takes it

module mem_burst_ctrl #(
  parameter int AW = 5,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW-1:0] cmd_len,
  input  logic          wdata_valid,
  output logic          wdata_ready,
  input  logic [DW-1:0] wdata,
  output logic          rdata_valid,
  input  logic          rdata_ready,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          done,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    RD_FETCH = 2'd2,
    RD_HOLD  = 2'd3
  } state_t;

  state_t        state, state_d;
  logic [AW-1:0] cnt, cnt_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] din_d;
  logic [DW-1:0] rdata_d;
  logic          we_d;
  logic          rvalid_d;
  logic          done_d;

  assign cmd_ready   = (state == IDLE);
  assign wdata_ready = (state == WRITE);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_din     <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      mem_we      <= we_d;
      mem_addr    <= addr_d;
      mem_din     <= din_d;
      rdata       <= rdata_d;
      rdata_valid <= rvalid_d;
      done        <= done_d;
    end
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    we_d     = 1'b0;
    din_d    = mem_din;
    rdata_d  = rdata;
    rvalid_d = rdata_valid;
    done_d   = 1'b0;
    // The address steps forward only once the write pulse it served is over,
    // so a stalled write beat lands on the already-advanced address and the
    // final pulse of a burst completes even while IDLE.
    addr_d   = mem_we ? mem_addr + AW'(1) : mem_addr;

    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          cnt_d   = cmd_len;
          addr_d  = cmd_addr;
          state_d = cmd_write ? WRITE : RD_FETCH;
        end
      end

      WRITE: begin
        if (wdata_valid) begin
          we_d  = 1'b1;
          din_d = wdata;
          if (cnt == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt - AW'(1);
          end
        end
      end

      RD_FETCH: begin
        rdata_d  = mem_dout;
        rvalid_d = 1'b1;
        state_d  = RD_HOLD;
      end

      RD_HOLD: begin
        if (rdata_ready) begin
          rvalid_d = 1'b0;
          if (cnt == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d   = cnt - AW'(1);
            addr_d  = mem_addr + AW'(1);
            state_d = RD_FETCH;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
module tb_mem_burst_ctrl;
  localparam int AW = 5;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [AW-1:0] cmd_len = '0;
  logic          wdata_valid = 1'b0;
  logic          wdata_ready;
  logic [DW-1:0] wdata = '0;
  logic          rdata_valid;
  logic          rdata_ready = 1'b0;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          done;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  logic [DW-1:0] mem     [32];
  logic [DW-1:0] exp_mem [32];
  logic [DW-1:0] wbuf    [32];

  int checks = 0;
  int errors = 0;
  int we_count = 0;
  int done_count = 0;

  always #5 clk = ~clk;

  mem_burst_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .busy(busy), .done(done),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // scratch memory model
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_din;
  assign mem_dout = mem[mem_addr];

  always @(negedge clk) begin
    if (mem_we) we_count++;
    if (done) done_count++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer a command from a negedge; returns at the negedge after acceptance.
  task automatic do_cmd(input logic wr, input int addr, input int len);
    int t = 0;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = AW'(addr);
    cmd_len   = AW'(len);
    while (!cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("cmd_ready_seen", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("busy_after_accept", busy, 1);
  endtask

  // Starts at the negedge right after a write command was accepted.
  task automatic write_data(input int addr, input int len, input logic [31:0] gap_mask);
    for (int i = 0; i <= len; i++) begin
      if (gap_mask[i]) begin
        wdata_valid = 1'b0;
        @(negedge clk);
        chk("gap_we", mem_we, 0);
      end
      wdata_valid = 1'b1;
      wdata = wbuf[i];
      @(negedge clk);
      chk("wr_we", mem_we, 1);
      chk("wr_addr", mem_addr, (addr + i) % 32);
      chk("wr_din", mem_din, wbuf[i]);
      exp_mem[(addr + i) % 32] = wbuf[i];
      if (i == len) begin
        chk("wr_done", done, 1);
        chk("wr_idle", cmd_ready, 1);
      end else begin
        chk("wr_nodone", done, 0);
        chk("wr_no_cmd_ready", cmd_ready, 0);
      end
    end
    wdata_valid = 1'b0;
  endtask

  // Starts at the negedge right after a read command was accepted.
  task automatic read_data(input int addr, input int len, input int stall_beat, input int stall_cycles);
    chk("rd_fetch_valid", rdata_valid, 0);
    for (int i = 0; i <= len; i++) begin
      @(negedge clk);
      chk("rd_valid", rdata_valid, 1);
      chk("rd_data", rdata, exp_mem[(addr + i) % 32]);
      chk("rd_addr", mem_addr, (addr + i) % 32);
      chk("rd_we", mem_we, 0);
      if (i == stall_beat) begin
        for (int s = 0; s < stall_cycles; s++) begin
          @(negedge clk);
          chk("stall_valid", rdata_valid, 1);
          chk("stall_data", rdata, exp_mem[(addr + i) % 32]);
          chk("stall_addr", mem_addr, (addr + i) % 32);
        end
      end
      rdata_ready = 1'b1;
      @(negedge clk);
      rdata_ready = 1'b0;
      chk("rd_consumed", rdata_valid, 0);
      chk("rd_done", done, (i == len) ? 1 : 0);
    end
  endtask

  initial begin
    int we0, dn0;
    for (int i = 0; i < 32; i++) begin
      exp_mem[i] = '0;
      wbuf[i] = '0;
    end

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_wdata_ready", wdata_ready, 0);
    chk("rst_rdata_valid", rdata_valid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_din", mem_din, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single write then read
    wbuf[0] = 16'hA5A5;
    we0 = we_count;
    do_cmd(1'b1, 3, 0);
    write_data(3, 0, 32'h0);
    @(negedge clk);
    chk("single_done_pulse", done, 0);
    chk("single_we_off", mem_we, 0);
    chk("single_we_count", we_count - we0, 1);
    do_cmd(1'b0, 3, 0);
    read_data(3, 0, -1, 0);
    @(negedge clk);

    // wrap burst with a write gap, read back with backpressure on beat 2
    for (int i = 0; i < 4; i++) wbuf[i] = DW'(i + 1);
    we0 = we_count;
    do_cmd(1'b1, 30, 3);
    write_data(30, 3, 32'h4);
    @(negedge clk);
    chk("wrap_we_count", we_count - we0, 4);
    do_cmd(1'b0, 30, 3);
    read_data(30, 3, 1, 5);
    @(negedge clk);

    // full memory burst
    for (int i = 0; i < 32; i++) wbuf[i] = DW'(i) ^ 16'h5555;
    we0 = we_count;
    dn0 = done_count;
    do_cmd(1'b1, 0, 31);
    write_data(0, 31, 32'h0);
    @(negedge clk);
    chk("full_we_count", we_count - we0, 32);
    chk("full_done_count", done_count - dn0, 1);
    do_cmd(1'b0, 0, 31);
    read_data(0, 31, -1, 0);
    @(negedge clk);

    // command overlap: read command held during a write burst
    wbuf[0] = 16'h0007; wbuf[1] = 16'h0008; wbuf[2] = 16'h0009;
    we0 = we_count;
    dn0 = done_count;
    do_cmd(1'b1, 5, 2);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'd5; cmd_len = 5'd2;
    write_data(5, 2, 32'h0);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("ovl_busy", busy, 1);
    chk("ovl_addr", mem_addr, 5);
    chk("ovl_we", mem_we, 0);
    chk("ovl_we_count", we_count - we0, 3);
    read_data(5, 2, -1, 0);
    @(negedge clk);
    chk("ovl_done_count", done_count - dn0, 2);

    // reset in the middle of a write burst
    dn0 = done_count;
    do_cmd(1'b1, 10, 5);
    wdata_valid = 1'b1;
    wdata = 16'h1111;
    @(negedge clk);
    wdata = 16'h2222;
    @(negedge clk);
    wdata = 16'h3333;
    @(negedge clk);
    chk("mid_we_before_rst", mem_we, 1);
    rst_n = 1'b0;
    wdata_valid = 1'b0;
    #1;
    chk("mid_rst_we", mem_we, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_din", mem_din, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_wdata_ready", wdata_ready, 0);
    chk("mid_rst_done", done, 0);
    exp_mem[10] = 16'h1111;
    exp_mem[11] = 16'h2222;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_no_done", done_count - dn0, 0);
    do_cmd(1'b0, 10, 1);
    read_data(10, 1, -1, 0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
